// File: rtl/vector_arb_pkg.sv
// vector_arb_pkg: shared types, limits and the lowest-set-bit helper for the vector arbiter.
package vector_arb_pkg;

  localparam int MAX_NREQ = 8;
  localparam int IDX_W    = 3;

  typedef enum logic {
    IDLE = 1'b0,
    PEND = 1'b1
  } state_t;

  typedef struct packed {
    logic             valid;
    logic [IDX_W-1:0] idx;
  } lowest_t;

  // Index of the lowest set bit (bit 0 is the most urgent); valid = 0 when v is empty.
  function automatic lowest_t lowest_set(input logic [MAX_NREQ-1:0] v);
    lowest_t r;
    r.valid = 1'b0;
    r.idx   = '0;
    for (int i = MAX_NREQ - 1; i >= 0; i--) begin
      if (v[i]) begin
        r.valid = 1'b1;
        r.idx   = IDX_W'(i);
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/vector_arbiter_prio_enc.sv
// prio_enc: lowest-index-wins priority encoder, returning the index of the
// most urgent set request and whether any request is set at all.
module prio_enc
  import vector_arb_pkg::*;
#(
  parameter int N = 8
) (
  input  logic [N-1:0]     i_req,
  output logic             o_valid,
  output logic [IDX_W-1:0] o_idx
);

  lowest_t w_res;

  assign w_res   = lowest_set(MAX_NREQ'(i_req));
  assign o_valid = w_res.valid;
  assign o_idx   = w_res.idx;

endmodule

// File: rtl/vector_arbiter.sv
// vector_arbiter: captures interrupt request edges, arbitrates them against the
// mask and the in-service register, flags a pending interrupt on nCC and drives
// the service-routine vector onto vec while the sequencer's nVECT is low.
// Build option: define VECTOR_ARB_AUTO_EOI_EN to hold isr at zero, ignore eoi
// and drop the in-service nesting restriction.
module vector_arbiter
  import vector_arb_pkg::*;
#(
  parameter int          NREQ     = 8,
  parameter logic [11:0] VBASE    = 12'h080,
  parameter int          VSTRIDE  = 4,
  parameter logic [11:0] SPURIOUS = 12'h07C
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [NREQ-1:0] irq,
  input  logic            mask_we,
  input  logic [NREQ-1:0] mask_din,
  input  logic            eoi,
  input  logic            nVECT,
  output logic [11:0]     vec,
  output logic            nCC,
  output logic [NREQ-1:0] ack,
  output logic [NREQ-1:0] isr,
  output logic [NREQ-1:0] mask
);

  state_t           r_state;
  state_t           w_state_next;
  logic [IDX_W-1:0] r_win;
  logic [NREQ-1:0]  r_irq_q;
  logic [NREQ-1:0]  r_pending;
  logic [NREQ-1:0]  r_mask;
  logic [NREQ-1:0]  r_isr;
  logic [NREQ-1:0]  r_ack;

  logic [NREQ-1:0]  w_edge;
  logic [NREQ-1:0]  w_allow;
  logic [NREQ-1:0]  w_eligible;
  logic [NREQ-1:0]  w_win_oh;
  logic [NREQ-1:0]  w_consume_oh;
  logic [NREQ-1:0]  w_pending_next;
  logic [NREQ-1:0]  w_isr_next;
  logic             w_win_valid;
  logic [IDX_W-1:0] w_win_idx;
  logic             w_consume;
  logic             w_withdraw;

  assign w_edge = irq & ~r_irq_q;

`ifdef VECTOR_ARB_AUTO_EOI_EN
  assign w_allow    = '1;
  assign w_isr_next = '0;
`else
  logic             w_isr_valid;
  logic [IDX_W-1:0] w_isr_idx;
  logic [NREQ-1:0]  w_isr_low_oh;

  // The lowest set isr bit is both the innermost active service and the eoi target.
  prio_enc #(.N(NREQ)) u_isr_enc (
    .i_req   (r_isr),
    .o_valid (w_isr_valid),
    .o_idx   (w_isr_idx)
  );

  assign w_isr_low_oh = NREQ'(1) << w_isr_idx;
  // Only requests strictly more urgent than the innermost active service may nest.
  assign w_allow      = w_isr_valid ? (w_isr_low_oh - NREQ'(1)) : '1;
  // eoi retires first, then a consumption in the same cycle marks its own bit.
  assign w_isr_next   = (r_isr & ~((eoi && w_isr_valid) ? w_isr_low_oh : '0)) | w_consume_oh;
`endif

  assign w_eligible = r_pending & ~r_mask & w_allow;

  prio_enc #(.N(NREQ)) u_win_enc (
    .i_req   (w_eligible),
    .o_valid (w_win_valid),
    .o_idx   (w_win_idx)
  );

  assign w_win_oh     = NREQ'(1) << r_win;
  assign w_consume    = (r_state == PEND) && !nVECT;
  // Withdrawal only applies when the sequencer is not taking the vector this cycle.
  assign w_withdraw   = (r_state == PEND) && nVECT &&
                        ((mask_we && |(mask_din & w_win_oh)) || ~|(r_pending & w_win_oh));
  assign w_consume_oh = w_consume ? w_win_oh : '0;
  // A fresh edge on the winner's line re-arms it even while it is being consumed.
  assign w_pending_next = (r_pending & ~w_consume_oh) | w_edge;

  // Next-state: offer the frozen winner until it is consumed or withdrawn.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE: if (w_win_valid) w_state_next = PEND;
      PEND: if (w_consume || w_withdraw) w_state_next = IDLE;
    endcase
  end

  // State and register update; the winner index is frozen on entry to PEND.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= IDLE;
      r_win     <= '0;
      r_irq_q   <= '0;
      r_pending <= '0;
      r_mask    <= '1;
      r_isr     <= '0;
      r_ack     <= '0;
    end else begin
      r_state   <= w_state_next;
      if (r_state == IDLE && w_win_valid) begin
        r_win <= w_win_idx;
      end
      r_irq_q   <= irq;
      r_pending <= w_pending_next;
      if (mask_we) begin
        r_mask <= mask_din;
      end
      r_isr     <= w_isr_next;
      r_ack     <= w_consume_oh;
    end
  end

  assign nCC  = (r_state != PEND);
  assign vec  = (r_state == PEND) ? (VBASE + 12'(r_win) * 12'(VSTRIDE)) : SPURIOUS;
  assign ack  = r_ack;
  assign isr  = r_isr;
  assign mask = r_mask;

endmodule

// File: tb/tb_vector_arbiter.sv
// tb_vector_arbiter: directed scenarios followed by a randomized run checked
// against a behavioural model of the arbiter's rules.
module tb_vector_arbiter;

  localparam int NREQ = 8;
`ifdef VECTOR_ARB_AUTO_EOI_EN
  localparam bit AUTO_EOI = 1'b1;
`else
  localparam bit AUTO_EOI = 1'b0;
`endif

  logic            clk;
  logic            reset;
  logic [NREQ-1:0] irq;
  logic            mask_we;
  logic [NREQ-1:0] mask_din;
  logic            eoi;
  logic            nVECT;
  logic [11:0]     vec;
  logic            nCC;
  logic [NREQ-1:0] ack;
  logic [NREQ-1:0] isr;
  logic [NREQ-1:0] mask;

  int errors = 0;
  int checks = 0;

  vector_arbiter #(.NREQ(NREQ)) dut (
    .clk      (clk),
    .reset    (reset),
    .irq      (irq),
    .mask_we  (mask_we),
    .mask_din (mask_din),
    .eoi      (eoi),
    .nVECT    (nVECT),
    .vec      (vec),
    .nCC      (nCC),
    .ack      (ack),
    .isr      (isr),
    .mask     (mask)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model: per-line flags plus the index currently offered (-1 = none).
  bit m_pend [NREQ];
  bit m_mask [NREQ];
  bit m_isr  [NREQ];
  bit m_prev [NREQ];
  int m_sel;
  int m_ack;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Advance the model across one clock edge, given the inputs seen at that edge.
  task automatic model_edge(input bit rst, input logic [NREQ-1:0] r_irq, input bit mwe,
                            input logic [NREQ-1:0] mdin, input bit e, input bit nv);
    int consumed;
    int limit;
    consumed = -1;
    if (rst) begin
      for (int i = 0; i < NREQ; i++) begin
        m_pend[i] = 0; m_isr[i] = 0; m_prev[i] = 0; m_mask[i] = 1;
      end
      m_sel = -1;
      m_ack = -1;
      return;
    end
    m_ack = -1;
    if (m_sel >= 0) begin
      if (!nv) begin
        consumed = m_sel;
        m_ack    = m_sel;
        m_sel    = -1;
      end else if ((mwe && mdin[m_sel]) || !m_pend[m_sel]) begin
        m_sel = -1;
      end
    end else begin
      limit = NREQ;
`ifndef VECTOR_ARB_AUTO_EOI_EN
      for (int i = 0; i < NREQ; i++) begin
        if (m_isr[i]) begin limit = i; break; end
      end
`endif
      for (int i = 0; i < limit; i++) begin
        if (m_pend[i] && !m_mask[i]) begin m_sel = i; break; end
      end
    end
`ifndef VECTOR_ARB_AUTO_EOI_EN
    if (e) begin
      for (int i = 0; i < NREQ; i++) begin
        if (m_isr[i]) begin m_isr[i] = 0; break; end
      end
    end
    if (consumed >= 0) m_isr[consumed] = 1;
`endif
    for (int i = 0; i < NREQ; i++) begin
      if (i == consumed) m_pend[i] = 0;
      if (r_irq[i] && !m_prev[i]) m_pend[i] = 1;
      m_prev[i] = r_irq[i];
      if (mwe) m_mask[i] = mdin[i];
    end
  endtask

  function automatic logic [NREQ-1:0] pack(input bit a [NREQ]);
    logic [NREQ-1:0] v;
    for (int i = 0; i < NREQ; i++) v[i] = a[i];
    return v;
  endfunction

  initial begin
    logic [NREQ-1:0] exp_ack;
    logic [11:0]     exp_vec;
    reset = 1'b1; irq = '0; mask_we = 1'b0; mask_din = '0; eoi = 1'b0; nVECT = 1'b1;
    tick(); tick();
    check("rst_ncc", nCC, 1);
    check("rst_vec", vec, 12'h07C);
    check("rst_mask", mask, 8'hFF);
    check("rst_isr", isr, 0);
    check("rst_ack", ack, 0);
    $display("step reset: nCC=%0b vec=%03h mask=%02h", nCC, vec, mask);

    reset = 1'b0; mask_we = 1'b1; mask_din = 8'h00; tick(); mask_we = 1'b0;
    check("mask_load", mask, 8'h00);

    // Single request on line 3.
    irq = 8'h08; tick(); irq = '0;
    check("t1_ncc_capture", nCC, 1);
    tick();
    check("t1_ncc", nCC, 0);
    check("t1_vec", vec, 12'h08C);
    nVECT = 1'b0; tick(); nVECT = 1'b1;
    check("t1_ack", ack, 8'h08);
    check("t1_isr", isr, AUTO_EOI ? 8'h00 : 8'h08);
    check("t1_ncc_after", nCC, 1);
    tick();
    check("t1_ack_pulse", ack, 0);
    $display("step t1: ack pulse seen, isr=%02h", isr);

`ifndef VECTOR_ARB_AUTO_EOI_EN
    eoi = 1'b1; tick(); eoi = 1'b0;
    check("t2_eoi_clear", isr, 0);
    // Simultaneous edges on 5 and 2: 2 wins, 5 blocked while 2 is in service.
    irq = 8'h24; tick(); irq = '0; tick();
    check("t2_ncc", nCC, 0);
    check("t2_vec", vec, 12'h088);
    nVECT = 1'b0; tick(); nVECT = 1'b1;
    check("t2_isr", isr, 8'h04);
    check("t2_ack", ack, 8'h04);
    tick(); tick();
    check("t2_blocked", nCC, 1);
    eoi = 1'b1; tick(); eoi = 1'b0;
    check("t2_eoi_isr", isr, 0);
    tick();
    check("t2_unblock_ncc", nCC, 0);
    check("t2_unblock_vec", vec, 12'h094);
    nVECT = 1'b0; tick(); nVECT = 1'b1;
    check("t2_ack5", ack, 8'h20);
    eoi = 1'b1; tick(); eoi = 1'b0;
    $display("step t2: priority and blocking done, isr=%02h", isr);

    // Nesting: service 4, then 1 preempts.
    irq = 8'h10; tick(); irq = '0; tick();
    nVECT = 1'b0; tick(); nVECT = 1'b1;
    check("t3_isr4", isr, 8'h10);
    irq = 8'h02; tick(); irq = '0; tick();
    check("t3_nest_ncc", nCC, 0);
    check("t3_nest_vec", vec, 12'h084);
    nVECT = 1'b0; tick(); nVECT = 1'b1;
    check("t3_isr_nested", isr, 8'h12);
    eoi = 1'b1; tick(); eoi = 1'b0;
    check("t3_eoi1", isr, 8'h10);
    eoi = 1'b1; tick(); eoi = 1'b0;
    check("t3_eoi2", isr, 8'h00);
    $display("step t3: nesting done");

    // Mask withdrawal of line 4 while offered.
    irq = 8'h10; tick(); irq = '0; tick();
    check("t4_vec", vec, 12'h090);
    mask_we = 1'b1; mask_din = 8'h10; tick(); mask_we = 1'b0;
    check("t4_withdraw_ncc", nCC, 1);
    check("t4_withdraw_ack", ack, 0);
    tick();
    check("t4_masked_ncc", nCC, 1);
    mask_we = 1'b1; mask_din = 8'h00; tick(); mask_we = 1'b0;
    check("t4_unmask_delay", nCC, 1);
    tick();
    check("t4_repend_ncc", nCC, 0);
    check("t4_repend_vec", vec, 12'h090);
    // Consume with a fresh edge on the same line: it stays pending.
    nVECT = 1'b0; irq = 8'h10; tick(); nVECT = 1'b1; irq = '0;
    check("t4_ack", ack, 8'h10);
    eoi = 1'b1; tick(); eoi = 1'b0;
    tick();
    check("t4_edge_wins_ncc", nCC, 0);
    check("t4_edge_wins_vec", vec, 12'h090);
    nVECT = 1'b0; tick(); nVECT = 1'b1;
    eoi = 1'b1; tick(); eoi = 1'b0;
    $display("step t4: withdrawal done");

    // nVECT low while idle.
    nVECT = 1'b0; tick();
    check("t5_vec", vec, 12'h07C);
    check("t5_ack", ack, 0);
    check("t5_ncc", nCC, 1);
    tick();
    check("t5_ack2", ack, 0);
    nVECT = 1'b1;
    $display("step t5: idle vector read done");

    // Reset during an in-flight consumption.
    irq = 8'h40; tick(); irq = '0; tick();
    check("t6_vec", vec, 12'h098);
    reset = 1'b1; nVECT = 1'b0; tick();
    check("t6_ncc", nCC, 1);
    check("t6_isr", isr, 0);
    check("t6_ack", ack, 0);
    // Line held high through reset release registers as an edge.
    irq = 8'h01; tick();
    reset = 1'b0; nVECT = 1'b1; mask_we = 1'b1; mask_din = 8'h00; tick(); mask_we = 1'b0;
    check("t7_ncc_idle", nCC, 1);
    tick();
    check("t7_ncc", nCC, 0);
    check("t7_vec", vec, 12'h080);
    irq = '0; nVECT = 1'b0; tick(); nVECT = 1'b1;
    check("t7_ack", ack, 8'h01);
    $display("step t6/t7: reset behaviour done");
`endif

    // Randomized run against the model.
    reset = 1'b1; irq = '0; mask_we = 1'b0; eoi = 1'b0; nVECT = 1'b1;
    model_edge(1'b1, irq, mask_we, mask_din, eoi, nVECT);
    tick();
    for (int c = 0; c < 3000; c++) begin
      reset    = ($urandom_range(0, 199) == 0);
      irq      = irq ^ NREQ'($urandom & $urandom & $urandom);
      mask_we  = ($urandom_range(0, 15) == 0);
      mask_din = NREQ'($urandom & $urandom);
      eoi      = ($urandom_range(0, 7) == 0);
      nVECT    = $urandom_range(0, 1) == 1;
      model_edge(reset, irq, mask_we, mask_din, eoi, nVECT);
      tick();
      exp_ack = (m_ack >= 0) ? (NREQ'(1) << m_ack) : '0;
      exp_vec = (m_sel >= 0) ? 12'(32'h080 + 4 * m_sel) : 12'h07C;
      check("rnd_ncc", nCC, (m_sel < 0) ? 1 : 0);
      check("rnd_vec", vec, exp_vec);
      check("rnd_ack", ack, exp_ack);
      check("rnd_isr", isr, pack(m_isr));
      check("rnd_mask", mask, pack(m_mask));
      if (ack != 0) $display("rnd cyc=%0d ack=%02h isr=%02h", c, ack, isr);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
